// File: rtl/seg_scan_if.sv
// Multiplexed 7-segment display bus: digit enables and segment pattern,
// both active low.
//   en  [3:0] : one-hot-low digit enable (0111 = digit0 ... 1110 = digit3)
//   seg [7:0] : segment pattern, bit6=a .. bit0=g, bit7 unused
// master = display scanner (drives), slave = decoder (samples).
interface seg_scan_if;
    logic [3:0] en;
    logic [7:0] seg;

    modport master (output en, output seg);
    modport slave  (input en, input seg);
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive side of the multiplexed 7-segment display bus. Samples the bus,
// waits for each digit's enable/pattern to be stable, decodes the pattern
// back to a digit code and publishes complete 4-digit frames atomically.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : en[3:0], seg[7:0] display bus
//   digit0..digit3      : last published frame (digit0 = leftmost)
//   frame_valid         : 1-cycle pulse when a frame is published
//   frame_changed       : with frame_valid, frame differs from previous one
//   dark                : no valid enable seen for TIMEOUT_CYC cycles
module seg_scan_decoder #(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 600000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       frame_valid,
    output logic       frame_changed,
    output logic       dark
);
    localparam int SW = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 4'h0;
            7'b1001111: decode = 4'h1;
            7'b0010010: decode = 4'h2;
            7'b0000110: decode = 4'h3;
            7'b1001100: decode = 4'h4;
            7'b0100100: decode = 4'h5;
            7'b0100000: decode = 4'h6;
            7'b0001111: decode = 4'h7;
            7'b0000000: decode = 4'h8;
            7'b0000100: decode = 4'h9;
            7'b1111111: decode = 4'hF;
            default:    decode = 4'hE;
        endcase
    endfunction

    // Input sample and the sample before it (for the stability compare).
    logic [3:0]       en_q, last_en_q;
    logic [6:0]       seg_q, last_seg_q;
    state_t           state_q, state_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [3:0][3:0]  digits_q, digits_d;
    logic             fv_q, fv_d, fc_q, fc_d;

    logic             en_valid, same, capture, publish;
    logic [1:0]       idx;

    always_comb begin
        en_valid = 1'b1;
        idx      = 2'd0;
        case (en_q)
            4'b0111: idx = 2'd0;
            4'b1011: idx = 2'd1;
            4'b1101: idx = 2'd2;
            4'b1110: idx = 2'd3;
            default: en_valid = 1'b0;
        endcase
        same = (en_q == last_en_q) && (seg_q == last_seg_q);

        state_d = state_q;
        stab_d  = stab_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                stab_d = '0;
                if (en_valid) begin
                    state_d = TRACK;
                    stab_d  = SW'(1);
                end
            end
            TRACK: begin
                if (!en_valid) begin
                    state_d = IDLE;
                    stab_d  = '0;
                end else if (same) begin
                    stab_d = stab_q + SW'(1);
                end else begin
                    // new digit or new pattern: restart the run
                    stab_d = SW'(1);
                end
            end
            HOLD: begin
                // seg changes are ignored here: one capture per dwell
                if (en_q != last_en_q) begin
                    state_d = en_valid ? TRACK : IDLE;
                    stab_d  = en_valid ? SW'(1) : '0;
                end
            end
            default: begin
                state_d = IDLE;
                stab_d  = '0;
            end
        endcase
        if (state_d == TRACK && stab_d == SW'(STABLE_CYC)) begin
            capture = 1'b1;
            state_d = HOLD;
        end

        // Timeout counter runs only while no valid enable is sampled.
        if (en_valid)
            to_d = '0;
        else if (to_q != CNT_W'(TIMEOUT_CYC))
            to_d = to_q + CNT_W'(1);
        else
            to_d = to_q;

        publish  = (mask_q == 4'hF);
        mask_d   = publish ? 4'h0 : mask_q;
        shadow_d = shadow_q;
        if (capture) begin
            shadow_d[idx] = decode(seg_q);
            mask_d[idx]   = 1'b1;
        end
        // Going dark discards any partial frame.
        if (to_d == CNT_W'(TIMEOUT_CYC))
            mask_d = 4'h0;

        digits_d = publish ? shadow_q : digits_q;
        fv_d     = publish;
        fc_d     = publish && (shadow_q != digits_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 4'hF;
            last_en_q  <= 4'hF;
            seg_q      <= 7'h7F;
            last_seg_q <= 7'h7F;
            state_q    <= IDLE;
            stab_q     <= '0;
            to_q       <= '0;
            mask_q     <= 4'h0;
            shadow_q   <= {4{4'hF}};
            digits_q   <= {4{4'hF}};
            fv_q       <= 1'b0;
            fc_q       <= 1'b0;
        end else begin
            en_q       <= bus.en;
            last_en_q  <= en_q;
            seg_q      <= bus.seg[6:0];
            last_seg_q <= seg_q;
            state_q    <= state_d;
            stab_q     <= stab_d;
            to_q       <= to_d;
            mask_q     <= mask_d;
            shadow_q   <= shadow_d;
            digits_q   <= digits_d;
            fv_q       <= fv_d;
            fc_q       <= fc_d;
        end
    end

    assign digit0        = digits_q[0];
    assign digit1        = digits_q[1];
    assign digit2        = digits_q[2];
    assign digit3        = digits_q[3];
    assign frame_valid   = fv_q;
    assign frame_changed = fc_q;
    // A valid sample drops dark immediately, before the counter clears.
    assign dark          = (to_q == CNT_W'(TIMEOUT_CYC)) && !en_valid;
endmodule
